// File: rtl/uart_bridge_ctrl.sv
// Byte-to-word bridge between a byte UART core and a word-addressed register port.
// Command byte (bit7 = write), then D_BYTES data bytes LSB-first; reads reply LSB-first.
module uart_bridge_ctrl #(
  parameter int unsigned D_BYTES        = 4,
  parameter int unsigned A_WIDTH        = 7,
  parameter int unsigned TIMEOUT_CYCLES = 104166,
  parameter bit          WR_ACK_EN      = 1'b1,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
  input  logic                   clk50MHz,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   tx_busy,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic [A_WIDTH-1:0]     if_addr_out,
  output logic [8*D_BYTES-1:0]   if_data_out,
  output logic                   if_wr_valid,
  output logic                   if_rd_req,
  input  logic                   if_rd_ack,
  input  logic [8*D_BYTES-1:0]   if_data_in,
  output logic                   frame_err
);

  localparam int unsigned DW = 8 * D_BYTES;
  localparam int unsigned IW = (D_BYTES > 1) ? $clog2(D_BYTES) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(D_BYTES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_COMMIT, RD_REQ, TX_ISSUE, TX_WAIT_HI, TX_WAIT_LO
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   tx_last;
  logic            tx_ack;
  logic [CW-1:0]   cnt;
  logic [1:0]      hi_cnt;
  logic [DW-1:0]   shadow;
  logic [DW-1:0]   rd_word;
  logic [7:0]      rd_lane;

  always_comb begin
    rd_lane = '0;
    for (int unsigned i = 0; i < D_BYTES; i++) begin
      if (idx == IW'(i)) rd_lane = rd_word[8*i +: 8];
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      tx_last     <= '0;
      tx_ack      <= 1'b0;
      cnt         <= '0;
      hi_cnt      <= '0;
      shadow      <= '0;
      rd_word     <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      if_addr_out <= '0;
      if_data_out <= '0;
      if_wr_valid <= 1'b0;
      if_rd_req   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      tx_valid    <= 1'b0;
      if_wr_valid <= 1'b0;
      // Bytes arriving while busy with a frame are dropped and flagged.
      frame_err   <= rx_valid && (state != IDLE) && (state != WR_DATA);

      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            if_addr_out <= rx_data[A_WIDTH-1:0];
            idx         <= '0;
            cnt         <= '0;
            state       <= rx_data[7] ? WR_DATA : RD_REQ;
          end
        end

        WR_DATA: begin
          if (rx_valid) begin
            for (int unsigned i = 0; i < D_BYTES; i++) begin
              if (idx == IW'(i)) shadow[8*i +: 8] <= rx_data;
            end
            cnt <= '0;
            if (idx == LAST_IDX) state <= WR_COMMIT;
            else                 idx   <= idx + 1'b1;
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            shadow    <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WR_COMMIT: begin
          if_data_out <= shadow;
          if_wr_valid <= 1'b1;
          idx         <= '0;
          tx_ack      <= 1'b1;
          tx_last     <= '0;
          state       <= WR_ACK_EN ? TX_ISSUE : IDLE;
        end

        RD_REQ: begin
          if (if_rd_ack) begin
            rd_word   <= if_data_in;
            if_rd_req <= 1'b0;
            idx       <= '0;
            tx_ack    <= 1'b0;
            tx_last   <= LAST_IDX;
            state     <= TX_ISSUE;
          end else begin
            if_rd_req <= 1'b1;
          end
        end

        TX_ISSUE: begin
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data  <= tx_ack ? ACK_BYTE : rd_lane;
            hi_cnt   <= '0;
            state    <= TX_WAIT_HI;
          end
        end

        TX_WAIT_HI: begin
          // A transmitter that never raises busy within 2 cycles is taken to have sent the byte.
          if (tx_busy) begin
            state <= TX_WAIT_LO;
          end else if (hi_cnt == 2'd2) begin
            if (idx == tx_last) state <= IDLE;
            else begin
              idx   <= idx + 1'b1;
              state <= TX_ISSUE;
            end
          end else begin
            hi_cnt <= hi_cnt + 1'b1;
          end
        end

        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (idx == tx_last) state <= IDLE;
            else begin
              idx   <= idx + 1'b1;
              state <= TX_ISSUE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bridge_ctrl.sv
// Directed bench for uart_bridge_ctrl: three instances (4-, 1- and 8-byte words) share one
// stimulus path; only the selected instance sees rx bytes and read acknowledges.
module tb_uart_bridge_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        rd_ack;
  logic [63:0] rd_word;
  int          sel;
  bit          busy_en;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rx = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        txv0, txv1, txv2, wrv0, wrv1, wrv2, rq0, rq1, rq2, fe0, fe1, fe2;
  logic [7:0]  txd0, txd1, txd2;
  logic [6:0]  ad0, ad1, ad2;
  logic [31:0] do0;
  logic [7:0]  do1;
  logic [63:0] do2;
  logic        rxv0, rxv1, rxv2, ack0, ack1, ack2;

  assign rxv0 = rx_valid && (sel == 0);
  assign rxv1 = rx_valid && (sel == 1);
  assign rxv2 = rx_valid && (sel == 2);
  assign ack0 = rd_ack && (sel == 0);
  assign ack1 = rd_ack && (sel == 1);
  assign ack2 = rd_ack && (sel == 2);

  uart_bridge_ctrl #(.D_BYTES(4), .A_WIDTH(7), .TIMEOUT_CYCLES(100), .WR_ACK_EN(1'b1), .ACK_BYTE(8'hA5)) u_dut4 (
    .clk50MHz(clk), .rst_n(rst_n), .rx_valid(rxv0), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(txv0), .tx_data(txd0), .if_addr_out(ad0), .if_data_out(do0), .if_wr_valid(wrv0),
    .if_rd_req(rq0), .if_rd_ack(ack0), .if_data_in(rd_word[31:0]), .frame_err(fe0));

  uart_bridge_ctrl #(.D_BYTES(1), .A_WIDTH(7), .TIMEOUT_CYCLES(100), .WR_ACK_EN(1'b1), .ACK_BYTE(8'hA5)) u_dut1 (
    .clk50MHz(clk), .rst_n(rst_n), .rx_valid(rxv1), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(txv1), .tx_data(txd1), .if_addr_out(ad1), .if_data_out(do1), .if_wr_valid(wrv1),
    .if_rd_req(rq1), .if_rd_ack(ack1), .if_data_in(rd_word[7:0]), .frame_err(fe1));

  uart_bridge_ctrl #(.D_BYTES(8), .A_WIDTH(7), .TIMEOUT_CYCLES(100), .WR_ACK_EN(1'b1), .ACK_BYTE(8'hA5)) u_dut8 (
    .clk50MHz(clk), .rst_n(rst_n), .rx_valid(rxv2), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(txv2), .tx_data(txd2), .if_addr_out(ad2), .if_data_out(do2), .if_wr_valid(wrv2),
    .if_rd_req(rq2), .if_rd_ack(ack2), .if_data_in(rd_word), .frame_err(fe2));

  logic        m_txv, m_wrv, m_rq, m_fe;
  logic [7:0]  m_txd;
  logic [6:0]  m_addr;
  logic [63:0] m_dout;

  always_comb begin
    m_txv = txv0; m_txd = txd0; m_addr = ad0; m_dout = 64'(do0);
    m_wrv = wrv0; m_rq = rq0; m_fe = fe0;
    if (sel == 1) begin
      m_txv = txv1; m_txd = txd1; m_addr = ad1; m_dout = 64'(do1);
      m_wrv = wrv1; m_rq = rq1; m_fe = fe1;
    end else if (sel == 2) begin
      m_txv = txv2; m_txd = txd2; m_addr = ad2; m_dout = do2;
      m_wrv = wrv2; m_rq = rq2; m_fe = fe2;
    end
  end

  // UART transmitter stand-in: busy for 6 cycles starting the cycle after tx_valid.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n)                busy_cnt <= 0;
    else if (m_txv && busy_en) busy_cnt <= 6;
    else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  logic [7:0]  tx_q[$];
  logic [63:0] mem [0:127];
  int wr_n = 0, fe_n = 0, busy_viol = 0, wr_cyc = 0, fe_cyc = 0;

  always @(negedge clk) begin
    if (m_txv) begin
      tx_q.push_back(m_txd);
      if (tx_busy) busy_viol++;
    end
    if (m_wrv) begin
      wr_n++;
      wr_cyc = cyc;
      mem[m_addr] = m_dout;
    end
    if (m_fe) begin
      fe_n++;
      fe_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_rx  = cyc;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [63:0] w, input int n);
    send_byte(cmd);
    tick;
    for (int i = 0; i < n; i++) begin
      send_byte(w[8*i +: 8]);
      tick;
    end
  endtask

  task automatic drain_tx(input int n, input logic [63:0] w, input string tag);
    int t = 0;
    while (tx_q.size() < n && t < 300) begin
      tick;
      t++;
    end
    repeat (30) tick;
    check({tag, " tx count"}, 64'(tx_q.size()), 64'(n));
    for (int i = 0; i < n && i < tx_q.size(); i++)
      check($sformatf("%s tx byte%0d", tag, i), 64'(tx_q[i]), 64'(w[8*i +: 8]));
    tx_q.delete();
  endtask

  task automatic do_read(input logic [7:0] cmd, input int n, input logic [63:0] w, input string tag);
    int t = 0;
    send_byte(cmd);
    while (!m_rq && t < 20) begin
      tick;
      t++;
    end
    check({tag, " rd_req rise"}, 64'(m_rq), 64'd1);
    check({tag, " addr"}, 64'(m_addr), 64'(cmd[6:0]));
    repeat (5) tick;
    check({tag, " rd_req held"}, 64'(m_rq), 64'd1);
    rd_word = mem[cmd[6:0]];
    rd_ack  = 1'b1;
    tick;
    rd_ack  = 1'b0;
    check({tag, " rd_req drop"}, 64'(m_rq), 64'd0);
    drain_tx(n, w, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1);
  end

  initial begin
    int w0, f0, t, n1, n2;
    logic [7:0] held;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rd_ack = 1'b0; rd_word = '0;
    sel = 0; busy_en = 1'b1;
    repeat (3) tick;
    check("reset tx_valid", 64'(m_txv), 64'd0);
    check("reset tx_data", 64'(m_txd), 64'd0);
    check("reset addr", 64'(m_addr), 64'd0);
    check("reset data_out", m_dout, 64'd0);
    check("reset strobes", 64'({m_wrv, m_rq, m_fe}), 64'd0);
    rst_n = 1'b1;
    tick;

    // Write 8'h85 / 11 22 33 44 with ACK
    w0 = wr_n;
    send_frame(8'h85, 64'h44332211, 4);
    repeat (3) tick;
    check("wr count", 64'(wr_n - w0), 64'd1);
    check("wr latency", 64'(wr_cyc - last_rx), 64'd2);
    check("wr addr", 64'(m_addr), 64'd5);
    check("wr data", m_dout, 64'h44332211);
    drain_tx(1, 64'hA5, "wr ack");

    // Read 8'h03 with a stray byte during the reply
    f0 = fe_n;
    send_byte(8'h03);
    t = 0;
    while (!m_rq && t < 20) begin tick; t++; end
    check("rd rd_req rise", 64'(m_rq), 64'd1);
    check("rd addr", 64'(m_addr), 64'd3);
    repeat (5) tick;
    check("rd rd_req held", 64'(m_rq), 64'd1);
    rd_word = 64'hDEADBEEF;
    rd_ack = 1'b1;
    tick;
    rd_ack = 1'b0;
    check("rd rd_req drop", 64'(m_rq), 64'd0);
    t = 0;
    while (tx_q.size() < 1 && t < 50) begin tick; t++; end
    held = m_txd;
    check("rd first byte", 64'(held), 64'hEF);
    send_byte(8'h77);
    check("drop frame_err", 64'(m_fe), 64'd1);
    check("drop tx_valid", 64'(m_txv), 64'd0);
    check("drop tx_data", 64'(m_txd), 64'hEF);
    drain_tx(4, 64'hDEADBEEF, "rd");
    check("drop fe count", 64'(fe_n - f0), 64'd1);
    check("tx busy order", 64'(busy_viol), 64'd0);

    // Timeout after 100 idle cycles
    f0 = fe_n; w0 = wr_n;
    send_byte(8'h81); tick;
    send_byte(8'hAA); tick;
    send_byte(8'hBB);
    t = 0;
    while (fe_n == f0 && t < 200) begin tick; t++; end
    check("to fe count", 64'(fe_n - f0), 64'd1);
    check("to fe cycle", 64'(fe_cyc - last_rx), 64'd101);
    check("to fe pulse", 64'(m_fe), 64'd0);
    check("to no write", 64'(wr_n - w0), 64'd0);
    check("to data kept", m_dout, 64'h44332211);
    send_frame(8'h86, 64'h40302010, 4);
    repeat (3) tick;
    check("post-to data", m_dout, 64'h40302010);
    check("post-to addr", 64'(m_addr), 64'd6);
    drain_tx(1, 64'hA5, "post-to ack");

    // Bytes in the exact expiry cycle are accepted
    f0 = fe_n;
    send_byte(8'h81); tick;
    send_byte(8'h0A);
    n1 = last_rx;
    wait_until(n1 + 100);
    send_byte(8'h0B);
    n2 = last_rx;
    wait_until(n2 + 100);
    send_byte(8'h0C); tick;
    send_byte(8'h0D);
    repeat (3) tick;
    check("edge no fe", 64'(fe_n - f0), 64'd0);
    check("edge data", m_dout, 64'h0D0C0B0A);
    drain_tx(1, 64'hA5, "edge ack");

    // Reset after the 2nd data byte
    w0 = wr_n; f0 = fe_n;
    send_byte(8'h81); tick;
    send_byte(8'h11); tick;
    send_byte(8'h22);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("rst addr", 64'(m_addr), 64'd0);
    check("rst data", m_dout, 64'd0);
    check("rst tx", 64'({m_txv, m_txd}), 64'd0);
    check("rst strobes", 64'({m_wrv, m_rq, m_fe}), 64'd0);
    tick;
    send_frame(8'h82, 64'h04030201, 4);
    repeat (3) tick;
    check("rst-after data", m_dout, 64'h04030201);
    check("rst-after addr", 64'(m_addr), 64'd2);
    check("rst-after wr count", 64'(wr_n - w0), 64'd1);
    check("rst-after fe", 64'(fe_n - f0), 64'd0);
    drain_tx(1, 64'hA5, "rst ack");

    // 1-byte words, transmitter that never raises busy
    sel = 1; busy_en = 1'b0;
    tick;
    send_frame(8'h8A, 64'h5C, 1);
    repeat (3) tick;
    check("d1 data", m_dout, 64'h5C);
    drain_tx(1, 64'hA5, "d1 ack");
    do_read(8'h0A, 1, 64'h5C, "d1 rd");

    // 8-byte words
    sel = 2; busy_en = 1'b1;
    tick;
    send_frame(8'h93, 64'hEFCDAB8967452301, 8);
    repeat (3) tick;
    check("d8 data", m_dout, 64'hEFCDAB8967452301);
    drain_tx(1, 64'hA5, "d8 ack");
    do_read(8'h13, 8, 64'hEFCDAB8967452301, "d8 rd");
    check("tx busy order end", 64'(busy_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
